// File: rtl/video_timing_gen.sv
// ---------------------------------------------------------------------------
// video_timing_gen
//   Raster timing generator for the LVDS transmitter, running on DotClock.
//   Horizontal/vertical counters produce active/sync regions. A three-stage
//   pipeline (counters -> pix_req -> registered outputs) keeps every output
//   registered, so outputs are glitch-free at the serializer sampling point.
//
// Optional build macro: VIDEO_TIMING_PATTERN_EN
//   Defined:   an internal 8-bar colour pattern replaces pix_*. pix_req is
//              held low.
//   Undefined: pixels come from the upstream request/1-cycle-latency port.
//
// Ports
//   DotClock     in   pixel clock (only clock)
//   rst_n        in   asynchronous active-low reset
//   enable       in   run request, acted on only at the frame boundary
//   pix_red/green/blue in [7:0]  upstream pixel, valid the cycle after pix_req
//   pix_req      out  request for the next active pixel
//   frame_start  out  one-cycle pulse with the first DataEnable of a frame
//   HSync/VSync  out  sync pulses, active level set by HS_POL/VS_POL
//   DataEnable   out  active-video qualifier
//   Red/Green/Blue out [7:0]  pixel colour, forced to 0 outside DataEnable
// ---------------------------------------------------------------------------
module video_timing_gen #(
  parameter int H_ACTIVE = 1024,
  parameter int H_FP     = 24,
  parameter int H_SYNC   = 136,
  parameter int H_BP     = 160,
  parameter int V_ACTIVE = 768,
  parameter int V_FP     = 3,
  parameter int V_SYNC   = 6,
  parameter int V_BP     = 29,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0
) (
  input  logic       DotClock,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [7:0] pix_red,
  input  logic [7:0] pix_green,
  input  logic [7:0] pix_blue,
  output logic       pix_req,
  output logic       frame_start,
  output logic       HSync,
  output logic       VSync,
  output logic       DataEnable,
  output logic [7:0] Red,
  output logic [7:0] Green,
  output logic [7:0] Blue
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);

  // Region boundaries as inclusive last values, so a region ending exactly
  // at total-1 never needs a value outside the counter width.
  localparam logic [HW-1:0] H_LAST       = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT_LAST   = HW'(H_ACTIVE - 1);
  localparam logic [HW-1:0] H_SYNC_FIRST = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SYNC_LAST  = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] V_LAST       = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT_LAST   = VW'(V_ACTIVE - 1);
  localparam logic [VW-1:0] V_SYNC_FIRST = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SYNC_LAST  = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t          state_reg, state_next;
  logic [HW-1:0]   h_cnt_reg, h_cnt_next;
  logic [VW-1:0]   v_cnt_reg, v_cnt_next;

  // -------------------------------------------------------------------------
  // Run control and raster counters
  // -------------------------------------------------------------------------
  always_ff @(posedge DotClock or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      h_cnt_reg <= '0;
      v_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      h_cnt_reg <= h_cnt_next;
      v_cnt_reg <= v_cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    h_cnt_next = h_cnt_reg;
    v_cnt_next = v_cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        h_cnt_next = '0;
        v_cnt_next = '0;
        if (enable) begin
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (h_cnt_reg == H_LAST) begin
          h_cnt_next = '0;
          if (v_cnt_reg == V_LAST) begin
            // Frame end is the only point where enable is honoured, so a
            // frame is never cut short.
            v_cnt_next = '0;
            if (!enable) begin
              state_next = ST_IDLE;
            end
          end else begin
            v_cnt_next = v_cnt_reg + 1'b1;
          end
        end else begin
          h_cnt_next = h_cnt_reg + 1'b1;
        end
      end
      default: begin
        state_next = ST_IDLE;
        h_cnt_next = '0;
        v_cnt_next = '0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Stage 0: region decode. In IDLE the counters sit at 0, which would decode
  // as the first active pixel, so everything is qualified by RUN.
  // -------------------------------------------------------------------------
  logic run_s0, act_s0, hs_s0, vs_s0, first_s0;

  assign run_s0   = (state_reg == ST_RUN);
  assign act_s0   = run_s0 && (h_cnt_reg <= H_ACT_LAST) && (v_cnt_reg <= V_ACT_LAST);
  assign hs_s0    = run_s0 && (h_cnt_reg >= H_SYNC_FIRST) && (h_cnt_reg <= H_SYNC_LAST);
  assign vs_s0    = run_s0 && (v_cnt_reg >= V_SYNC_FIRST) && (v_cnt_reg <= V_SYNC_LAST);
  assign first_s0 = act_s0 && (h_cnt_reg == '0) && (v_cnt_reg == '0);

  // -------------------------------------------------------------------------
  // Stage 1: delayed qualifiers; act_d1_reg doubles as the pixel request.
  // -------------------------------------------------------------------------
  logic act_d1_reg, hs_d1_reg, vs_d1_reg, first_d1_reg;

  always_ff @(posedge DotClock or negedge rst_n) begin
    if (!rst_n) begin
      act_d1_reg   <= 1'b0;
      hs_d1_reg    <= 1'b0;
      vs_d1_reg    <= 1'b0;
      first_d1_reg <= 1'b0;
    end else begin
      act_d1_reg   <= act_s0;
      hs_d1_reg    <= hs_s0;
      vs_d1_reg    <= vs_s0;
      first_d1_reg <= first_s0;
    end
  end

  // Colour source seen by stage 2
  logic [7:0] src_red, src_green, src_blue;

`ifdef VIDEO_TIMING_PATTERN_EN
  // Bar index (h_cnt*8)/H_ACTIVE without a divider: bar_ge[gi] is set once
  // h_cnt reaches the first pixel of bar gi, i.e. ceil(gi*H_ACTIVE/8).
  logic [7:1] bar_ge;
  logic [2:0] bar_idx;
  logic [7:0] pat_red_reg, pat_green_reg, pat_blue_reg;
  logic       unused_pix;

  genvar gi;
  generate
    for (gi = 1; gi < 8; gi++) begin : g_bar
      assign bar_ge[gi] = (h_cnt_reg >= HW'((gi * H_ACTIVE + 7) / 8));
    end
  endgenerate

  always_comb begin
    bar_idx = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (bar_ge[i]) begin
        bar_idx = 3'(i);
      end
    end
  end

  // Bars white, yellow, cyan, green, magenta, red, blue, black map onto
  // inverted index bits: R = ~idx[1], G = ~idx[2], B = ~idx[0].
  always_ff @(posedge DotClock or negedge rst_n) begin
    if (!rst_n) begin
      pat_red_reg   <= 8'h00;
      pat_green_reg <= 8'h00;
      pat_blue_reg  <= 8'h00;
    end else begin
      pat_red_reg   <= {8{~bar_idx[1]}};
      pat_green_reg <= {8{~bar_idx[2]}};
      pat_blue_reg  <= {8{~bar_idx[0]}};
    end
  end

  assign unused_pix = ^{pix_red, pix_green, pix_blue};
  assign src_red    = pat_red_reg;
  assign src_green  = pat_green_reg;
  assign src_blue   = pat_blue_reg;
  assign pix_req    = 1'b0;
`else
  assign src_red    = pix_red;
  assign src_green  = pix_green;
  assign src_blue   = pix_blue;
  assign pix_req    = act_d1_reg;
`endif

  // -------------------------------------------------------------------------
  // Stage 2: registered outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge DotClock or negedge rst_n) begin
    if (!rst_n) begin
      DataEnable  <= 1'b0;
      frame_start <= 1'b0;
      HSync       <= ~HS_POL;
      VSync       <= ~VS_POL;
      Red         <= 8'h00;
      Green       <= 8'h00;
      Blue        <= 8'h00;
    end else begin
      DataEnable  <= act_d1_reg;
      frame_start <= first_d1_reg;
      HSync       <= hs_d1_reg ? HS_POL : ~HS_POL;
      VSync       <= vs_d1_reg ? VS_POL : ~VS_POL;
      Red         <= act_d1_reg ? src_red   : 8'h00;
      Green       <= act_d1_reg ? src_green : 8'h00;
      Blue        <= act_d1_reg ? src_blue  : 8'h00;
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_video_timing_gen
//   Directed bench for video_timing_gen on a small raster:
//   H 8/2/3/1 (H_TOTAL=14), V 4/1/2/1 (V_TOTAL=8), one frame = 112 cycles.
//   Two instances share inputs: dut (active-low syncs) and dut_p (active-high).
//   An upstream model answers each pix_req one cycle later with tagged data
//   (Red 8'h10+pixel, Green 8'h20+pixel, Blue 8'h30+pixel) and drives junk
//   otherwise, so any leak outside DataEnable is visible.
// ---------------------------------------------------------------------------
module tb_video_timing_gen;

  logic       DotClock;
  logic       rst_n;
  logic       enable;
  logic [7:0] pix_red, pix_green, pix_blue;

  logic       pix_req, frame_start, HSync, VSync, DataEnable;
  logic [7:0] Red, Green, Blue;
  logic       pix_req_p, frame_start_p, HSync_p, VSync_p, DataEnable_p;
  logic [7:0] Red_p, Green_p, Blue_p;

  int checks = 0;
  int errors = 0;

  localparam int FRAME = 112;
  localparam int BIG   = 1 << 30;

  video_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut (
    .DotClock(DotClock), .rst_n(rst_n), .enable(enable),
    .pix_red(pix_red), .pix_green(pix_green), .pix_blue(pix_blue),
    .pix_req(pix_req), .frame_start(frame_start), .HSync(HSync), .VSync(VSync),
    .DataEnable(DataEnable), .Red(Red), .Green(Green), .Blue(Blue)
  );

  video_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) dut_p (
    .DotClock(DotClock), .rst_n(rst_n), .enable(enable),
    .pix_red(pix_red), .pix_green(pix_green), .pix_blue(pix_blue),
    .pix_req(pix_req_p), .frame_start(frame_start_p), .HSync(HSync_p), .VSync(VSync_p),
    .DataEnable(DataEnable_p), .Red(Red_p), .Green(Green_p), .Blue(Blue_p)
  );

  initial begin
    DotClock = 1'b0;
    forever #5 DotClock = ~DotClock;
  end

  // Upstream source: data for a request seen after posedge k is presented at
  // the following negedge and sampled by the DUT at posedge k+1.
  initial begin
    int idx;
    idx = 0;
    pix_red = 8'h00; pix_green = 8'h00; pix_blue = 8'h00;
    forever begin
      @(negedge DotClock);
      if (!rst_n) begin
        idx = 0;
        pix_red = 8'hA5; pix_green = 8'h5A; pix_blue = 8'h3C;
      end else if (pix_req) begin
        pix_red   = 8'h10 + 8'(idx);
        pix_green = 8'h20 + 8'(idx);
        pix_blue  = 8'h30 + 8'(idx);
        idx = (idx + 1) % 8;
      end else begin
        pix_red = 8'hA5; pix_green = 8'h5A; pix_blue = 8'h3C;
      end
    end
  end

  // Observed vector: {DE, HSync, VSync, frame_start, pix_req, R, G, B}
  function automatic logic [28:0] obs_vec();
    return {DataEnable, HSync, VSync, frame_start, pix_req, Red, Green, Blue};
  endfunction

  // Expected outputs when stage-0 position p (cycles since the frame's
  // h=0,v=0) is at the output; positions outside [0,p_end) are idle.
  // pix_req belongs to position p+1 (one cycle less latency).
  function automatic logic [28:0] exp_vec(input int p, input int p_end);
    logic de, hs, vs, fs, req;
    logic [7:0] r, g, b;
    int h, v;
    de = 1'b0; hs = 1'b1; vs = 1'b1; fs = 1'b0; req = 1'b0;
    r = 8'h00; g = 8'h00; b = 8'h00;
    if (p >= 0 && p < p_end) begin
      h  = p % 14;
      v  = (p / 14) % 8;
      de = (h < 8) && (v < 4);
      hs = !(h >= 10 && h <= 12);
      vs = !(v == 5 || v == 6);
      fs = (h == 0) && (v == 0);
      if (de) begin
`ifdef VIDEO_TIMING_PATTERN_EN
        r = (h == 0 || h == 1 || h == 4 || h == 5) ? 8'hFF : 8'h00;
        g = (h <= 3) ? 8'hFF : 8'h00;
        b = (h == 0 || h == 2 || h == 4 || h == 6) ? 8'hFF : 8'h00;
`else
        r = 8'h10 + 8'(h);
        g = 8'h20 + 8'(h);
        b = 8'h30 + 8'(h);
`endif
      end
    end
`ifndef VIDEO_TIMING_PATTERN_EN
    if (p + 1 >= 0 && p + 1 < p_end) begin
      int hq, vq;
      hq  = (p + 1) % 14;
      vq  = ((p + 1) / 14) % 8;
      req = (hq < 8) && (vq < 4);
    end
`endif
    return {de, hs, vs, fs, req, r, g, b};
  endfunction

`ifdef VIDEO_TIMING_PATTERN_EN
  localparam int REQ_PER_FRAME = 0;
`else
  localparam int REQ_PER_FRAME = 32;
`endif

  task automatic tick();
    @(posedge DotClock);
    #1;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [28:0] e;
    enable = 1'b1;
    rst_n  = 1'b0;
    repeat (3) tick();
    e = exp_vec(-10, 0);
    checks++;
    if (obs_vec() !== e) begin
      errors++;
      $display("FAIL reset_outputs got %h exp %h", obs_vec(), e);
    end
    checks++;
    if ({HSync_p, VSync_p} !== 2'b00) begin
      errors++;
      $display("FAIL reset_pol_idle got %b exp 00", {HSync_p, VSync_p});
    end
    // Released with enable low: must stay idle
    enable = 1'b0;
    rst_n  = 1'b1;
    for (int c = 0; c < 30; c++) begin
      tick();
      checks++;
      if (obs_vec() !== e) begin
        errors++;
        $display("FAIL idle_hold c=%0d got %h exp %h", c, obs_vec(), e);
      end
    end
    $display("test_reset done checks=%0d errors=%0d", checks, errors);
  endtask

  // Two back-to-back frames, every output every cycle
  task automatic test_frame();
    logic [28:0] e;
    int de_cnt, req_cnt, fs_cnt, p;
    de_cnt = 0; req_cnt = 0; fs_cnt = 0;
    enable = 1'b0;
    reset_dut();
    enable = 1'b1;
    for (int c = 1; c <= 3 + 2 * FRAME; c++) begin
      tick();
      p = c - 3;
      e = exp_vec(p, BIG);
      checks++;
      if (obs_vec() !== e) begin
        errors++;
        $display("FAIL frame c=%0d got %h exp %h", c, obs_vec(), e);
      end
      if (p >= 0 && p < 2 * FRAME) begin
        de_cnt += int'(DataEnable);
        fs_cnt += int'(frame_start);
      end
      if (p + 1 >= 0 && p + 1 < 2 * FRAME) req_cnt += int'(pix_req);
    end
    checks++;
    if (de_cnt !== 64) begin
      errors++;
      $display("FAIL de_count got %0d exp 64", de_cnt);
    end
    checks++;
    if (req_cnt !== 2 * REQ_PER_FRAME) begin
      errors++;
      $display("FAIL req_count got %0d exp %0d", req_cnt, 2 * REQ_PER_FRAME);
    end
    checks++;
    if (fs_cnt !== 2) begin
      errors++;
      $display("FAIL frame_start_count got %0d exp 2", fs_cnt);
    end
    $display("test_frame done checks=%0d errors=%0d", checks, errors);
  endtask

  // enable dropped at v=2: the frame still completes, then idle
  task automatic test_enable_drop();
    logic [28:0] e;
    int req_cnt;
    req_cnt = 0;
    enable = 1'b0;
    reset_dut();
    enable = 1'b1;
    for (int c = 1; c <= 3 + FRAME + 20; c++) begin
      tick();
      if (c == 29) enable = 1'b0;  // counters now at h=0, v=2
      e = exp_vec(c - 3, FRAME);
      checks++;
      if (obs_vec() !== e) begin
        errors++;
        $display("FAIL enable_drop c=%0d got %h exp %h", c, obs_vec(), e);
      end
      req_cnt += int'(pix_req);
    end
    checks++;
    if (req_cnt !== REQ_PER_FRAME) begin
      errors++;
      $display("FAIL drop_req_count got %0d exp %0d", req_cnt, REQ_PER_FRAME);
    end
    $display("test_enable_drop done checks=%0d errors=%0d", checks, errors);
  endtask

  // Reset pulsed with counters at h=5, v=1; outputs clear without a clock edge
  task automatic test_reset_mid();
    logic [28:0] e;
    int de_cnt, fs_cnt;
    de_cnt = 0; fs_cnt = 0;
    enable = 1'b0;
    reset_dut();
    enable = 1'b1;
    repeat (20) tick();
    e = exp_vec(17, BIG);
    checks++;
    if (obs_vec() !== e) begin
      errors++;
      $display("FAIL pre_reset got %h exp %h", obs_vec(), e);
    end
    #2;
    rst_n = 1'b0;
    #1;
    e = exp_vec(-10, 0);
    checks++;
    if (obs_vec() !== e) begin
      errors++;
      $display("FAIL async_reset got %h exp %h", obs_vec(), e);
    end
    checks++;
    if ({HSync_p, VSync_p, DataEnable_p} !== 3'b000) begin
      errors++;
      $display("FAIL async_reset_pol got %b exp 000", {HSync_p, VSync_p, DataEnable_p});
    end
    tick();
    rst_n = 1'b1;
    for (int c = 1; c <= 3 + FRAME; c++) begin
      tick();
      e = exp_vec(c - 3, BIG);
      checks++;
      if (obs_vec() !== e) begin
        errors++;
        $display("FAIL restart c=%0d got %h exp %h", c, obs_vec(), e);
      end
      if (c - 3 >= 0 && c - 3 < FRAME) begin
        de_cnt += int'(DataEnable);
        fs_cnt += int'(frame_start);
      end
    end
    checks++;
    if (de_cnt !== 32 || fs_cnt !== 1) begin
      errors++;
      $display("FAIL restart_counts got de=%0d fs=%0d exp de=32 fs=1", de_cnt, fs_cnt);
    end
    $display("test_reset_mid done checks=%0d errors=%0d", checks, errors);
  endtask

  // Active-high instance: same timing, inverted sync levels
  task automatic test_polarity();
    logic [28:0] e;
    logic [2:0]  exp_p;
    enable = 1'b0;
    reset_dut();
    enable = 1'b1;
    for (int c = 1; c <= 3 + FRAME; c++) begin
      tick();
      e = exp_vec(c - 3, BIG);
      exp_p = {~e[27], ~e[26], e[28]};
      checks++;
      if ({HSync_p, VSync_p, DataEnable_p} !== exp_p) begin
        errors++;
        $display("FAIL polarity c=%0d got %b exp %b", c, {HSync_p, VSync_p, DataEnable_p}, exp_p);
      end
    end
    enable = 1'b0;
    $display("test_polarity done checks=%0d errors=%0d", checks, errors);
  endtask

  initial begin
    rst_n  = 1'b0;
    enable = 1'b0;
    test_reset();
    test_frame();
    test_enable_drop();
    test_reset_mid();
    test_polarity();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
